// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the N-lane memory controller: one request in flight, MRead/MWrite pulse, wait MReady, write back loads.
// Define MAU_TIMEOUT_EN to add an MReady watchdog that aborts a request after TIMEOUT cycles in WAIT.
`ifndef N_CORES
`define N_CORES 4
`endif

module mem_access_unit #(
  parameter int N_CORES = `N_CORES,
  parameter int DW      = 16
`ifdef MAU_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_start,
  input  logic                    st_start,
  input  logic [N_CORES-1:0]      core_en,
  input  logic [N_CORES*DW-1:0]   addr_in,
  input  logic [N_CORES*DW-1:0]   data_in,
  output logic                    busy,
  output logic                    done,
  output logic [N_CORES-1:0]      wb_en,
  output logic [N_CORES*DW-1:0]   wb_data,
  output logic                    illegal,
  output logic                    timeout,
  output logic                    MRead,
  output logic                    MWrite,
  input  logic                    MReady,
  output logic [N_CORES-1:0]      en,
  output logic [N_CORES*DW-1:0]   addr,
  output logic [N_CORES*DW-1:0]   data,
  input  logic [N_CORES*DW-1:0]   q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  logic [1:0] state;
  logic       is_load;

`ifdef MAU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt;
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state != S_IDLE);

  // Pulse outputs default low every cycle; each state raises only what it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      is_load <= 1'b0;
      MRead   <= 1'b0;
      MWrite  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      wb_en   <= '0;
      wb_data <= '0;
      en      <= '0;
      addr    <= '0;
      data    <= '0;
`ifdef MAU_TIMEOUT_EN
      timeout  <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      MRead   <= 1'b0;
      MWrite  <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      wb_en   <= '0;
`ifdef MAU_TIMEOUT_EN
      timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (ld_start && st_start) begin
            illegal <= 1'b1;
          end else if (ld_start || st_start) begin
            is_load <= ld_start;
            en      <= core_en;
            addr    <= addr_in;
            data    <= data_in;
            // An empty mask has nothing to fetch, so skip the controller entirely.
            if (core_en == '0) begin
              state <= S_WB;
              done  <= 1'b1;
            end else begin
              state  <= S_ISSUE;
              MRead  <= ld_start;
              MWrite <= st_start;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
`ifdef MAU_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (MReady) begin
            state <= S_WB;
            done  <= 1'b1;
            if (is_load) begin
              wb_en <= en;
            end
            for (int i = 0; i < N_CORES; i++) begin
              if (is_load && en[i]) begin
                wb_data[i*DW +: DW] <= q[i*DW +: DW];
              end
            end
          end
`ifdef MAU_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
